regfile_access_arbiter: RTL and testbench

- Shares the 16x32 single-read/single-write register file between two requesters: port 0 is the control unit and port 1 is the debug/load port.
- Performs round-robin arbitration with a one-cycle req/gnt handshake.
- Returns read data one cycle after grant.
- Runs a sequenced "sweep" that writes SWEEP_VALUE into every register, one per cycle, blocking both requesters.

---
 rtl/regfile_arb_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 49 ++++
 rtl/regfile_access_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_access_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared encodings and defaults for the register-file access arbiter.
package regfile_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  localparam int unsigned PORT_CTRL = 0;
  localparam int unsigned PORT_DBG  = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StSweep = ST_SWEEP
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way arbiter with a one-hot grant.
// Round-robin by default; REGFILE_ARB_FIXED_PRIORITY_EN makes port 0 always win.
module rr_arbiter_2 (
  input  logic       in_clk,
  input  logic       in_clr,
  input  logic [1:0] in_req,
  output logic [1:0] out_gnt
);

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
  logic unused_clk_clr;
  assign unused_clk_clr = in_clk ^ in_clr;

  always_comb begin
    out_gnt = 2'b00;
    if (in_req[0]) begin
      out_gnt = 2'b01;
    end else if (in_req[1]) begin
      out_gnt = 2'b10;
    end
  end
`else
  // ptr_q names the port that wins the next contention.
  logic ptr_q, ptr_d;

  always_comb begin
    out_gnt = 2'b00;
    ptr_d   = ptr_q;
    case (in_req)
      2'b01:   out_gnt = 2'b01;
      2'b10:   out_gnt = 2'b10;
      2'b11:   out_gnt = ptr_q ? 2'b10 : 2'b01;
      default: out_gnt = 2'b00;
    endcase
    if (|out_gnt) begin
      ptr_d = out_gnt[0];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_clr) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a single-read/single-write register file between two requesters and runs a clear sweep.
// Build option: REGFILE_ARB_FIXED_PRIORITY_EN selects fixed priority for port 0.
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned         DATA_W      = DEF_DATA_W,
  parameter int unsigned         ADDR_W      = DEF_ADDR_W,
  parameter int unsigned         NUM_REGS    = 16,
  parameter logic [DATA_W-1:0]   SWEEP_VALUE = '0
) (
  input  logic              in_clk,
  input  logic              in_clr,
  input  logic              in_req0,
  input  logic              in_req1,
  input  logic              in_we0,
  input  logic              in_we1,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_wdata0,
  input  logic [DATA_W-1:0] in_wdata1,
  output logic              out_gnt0,
  output logic              out_gnt1,
  output logic              out_rvalid0,
  output logic              out_rvalid1,
  output logic [DATA_W-1:0] out_rdata0,
  output logic [DATA_W-1:0] out_rdata1,
  input  logic              in_sweep_start,
  output logic              out_busy,
  output logic [ADDR_W-1:0] out_Aselect,
  output logic [ADDR_W-1:0] out_Cselect,
  output logic [DATA_W-1:0] out_Cdata,
  output logic              out_write,
  input  logic [DATA_W-1:0] in_Adata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        arb_req, gnt;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // A sweep start or a reset beats any request in the same cycle.
  assign arb_req = (state_q == StIdle && !in_sweep_start && !in_clr) ?
                   {in_req1, in_req0} : 2'b00;

  rr_arbiter_2 u_arb (
    .in_clk  (in_clk),
    .in_clr  (in_clr),
    .in_req  (arb_req),
    .out_gnt (gnt)
  );

  assign out_gnt0    = gnt[PORT_CTRL];
  assign out_gnt1    = gnt[PORT_DBG];
  assign out_rvalid0 = rvalid0_q;
  assign out_rvalid1 = rvalid1_q;
  assign out_rdata0  = rdata0_q;
  assign out_rdata1  = rdata1_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_busy    = 1'b0;
    out_write   = 1'b0;
    out_Aselect = '0;
    out_Cselect = '0;
    out_Cdata   = '0;
    if (!in_clr) begin
      case (state_q)
        StIdle: begin
          if (in_sweep_start) begin
            state_d = StSweep;
            count_d = '0;
          end else if (gnt[PORT_CTRL]) begin
            out_Aselect = in_addr0;
            out_Cselect = in_addr0;
            out_Cdata   = in_wdata0;
            out_write   = in_we0;
          end else if (gnt[PORT_DBG]) begin
            out_Aselect = in_addr1;
            out_Cselect = in_addr1;
            out_Cdata   = in_wdata1;
            out_write   = in_we1;
          end
        end
        StSweep: begin
          out_busy    = 1'b1;
          out_write   = 1'b1;
          out_Cselect = count_q;
          out_Cdata   = SWEEP_VALUE;
          count_d     = count_q + 1'b1;
          if (count_q == ADDR_W'(NUM_REGS - 1)) begin
            state_d = StIdle;
            count_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_clr) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rvalid0_q <= gnt[PORT_CTRL] & ~in_we0;
      rvalid1_q <= gnt[PORT_DBG] & ~in_we1;
      if (gnt[PORT_CTRL] && !in_we0) begin
        rdata0_q <= in_Adata;
      end
      if (gnt[PORT_DBG] && !in_we1) begin
        rdata1_q <= in_Adata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with an attached register file and read scoreboard.
module tb_regfile_access_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0, req1, we0, we1, sweep_start;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, write;
  logic [31:0] rdata0, rdata1, cdata, adata;
  logic [3:0]  asel, csel;

  logic [31:0] rf        [16];
  logic [31:0] mem_model [16];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  pend   = 2'b00;
  logic [1:0]  rv_exp = 2'b00;
  logic        mon_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  regfile_access_arbiter dut (
    .in_clk         (clk),
    .in_clr         (clr),
    .in_req0        (req0),
    .in_req1        (req1),
    .in_we0         (we0),
    .in_we1         (we1),
    .in_addr0       (addr0),
    .in_addr1       (addr1),
    .in_wdata0      (wdata0),
    .in_wdata1      (wdata1),
    .out_gnt0       (gnt0),
    .out_gnt1       (gnt1),
    .out_rvalid0    (rvalid0),
    .out_rvalid1    (rvalid1),
    .out_rdata0     (rdata0),
    .out_rdata1     (rdata1),
    .in_sweep_start (sweep_start),
    .out_busy       (busy),
    .out_Aselect    (asel),
    .out_Cselect    (csel),
    .out_Cdata      (cdata),
    .out_write      (write),
    .in_Adata       (adata)
  );

  // External register file.
  always @(posedge clk) if (write === 1'b1) rf[csel] <= cdata;
  assign adata = rf[asel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read-data scoreboard: rvalid must match the bench's own schedule.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rvalid0", {31'b0, rvalid0}, {31'b0, rv_exp[0]});
      chk("rvalid1", {31'b0, rvalid1}, {31'b0, rv_exp[1]});
      if (rvalid0 === 1'b1) begin
        if (q0.size() > 0) chk("rdata0", rdata0, q0.pop_front());
        else chk("rdata0_unexpected", {31'b0, rvalid0}, 32'd0);
      end
      if (rvalid1 === 1'b1) begin
        if (q1.size() > 0) chk("rdata1", rdata1, q1.pop_front());
        else chk("rdata1_unexpected", {31'b0, rvalid1}, 32'd0);
      end
      rv_exp = pend;
      pend   = 2'b00;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single-port access with the other port idle; granted in the same cycle.
  task automatic access(input int p, input logic we, input logic [3:0] addr, input logic [31:0] d);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = d;
    end
    if (we) begin
      mem_model[addr] = d;
    end else begin
      pend[p] = 1'b1;
      if (p == 0) q0.push_back(mem_model[addr]);
      else q1.push_back(mem_model[addr]);
    end
    @(negedge clk);
    chk("acc_gnt0", {31'b0, gnt0}, {31'b0, p == 0});
    chk("acc_gnt1", {31'b0, gnt1}, {31'b0, p == 1});
    chk("acc_write", {31'b0, write}, {31'b0, we});
    chk("acc_csel", {28'b0, csel}, {28'b0, addr});
    chk("acc_asel", {28'b0, asel}, {28'b0, addr});
    if (we) chk("acc_cdata", cdata, d);
    tick();
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic do_reset;
    clr = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int g;
    clr = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; sweep_start = 1'b0;
    addr0 = 4'd0; addr1 = 4'd0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 16; i++) begin
      rf[i]        = 32'h0A00_0000 + i;
      mem_model[i] = 32'h0A00_0000 + i;
    end
    tick();
    @(negedge clk);
    chk("reset_gnt0", {31'b0, gnt0}, 32'd0);
    chk("reset_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_write", {31'b0, write}, 32'd0);
    chk("reset_csel", {28'b0, csel}, 32'd0);
    tick();
    clr = 1'b0; req0 = 1'b0; mon_en = 1'b1;

    // Write then read back on port 0.
    access(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    access(0, 1'b0, 4'd3, 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("rdata0_held", rdata0, 32'hDEAD_BEEF);
    tick();

    // Contention from reset.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd3; addr1 = 4'd5;
    for (int i = 0; i < 6; i++) begin
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
      g = 0;
`else
      g = i % 2;
`endif
      pend[g] = 1'b1;
      if (g == 0) q0.push_back(mem_model[3]);
      else q1.push_back(mem_model[5]);
      @(negedge clk);
      chk("both_gnt0", {31'b0, gnt0}, {31'b0, g == 0});
      chk("both_gnt1", {31'b0, gnt1}, {31'b0, g == 1});
      chk("both_asel", {28'b0, asel}, (g == 0) ? 32'd3 : 32'd5);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // Fill, full sweep, read everything back.
    for (int i = 0; i < 16; i++) access(i % 2, 1'b1, 4'(i), 32'h1111_1111);
    sweep_start = 1'b1;
    @(negedge clk);
    chk("sw_start_busy", {31'b0, busy}, 32'd0);
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sw_busy", {31'b0, busy}, 32'd1);
      chk("sw_write", {31'b0, write}, 32'd1);
      chk("sw_csel", {28'b0, csel}, i);
      chk("sw_cdata", cdata, 32'd0);
      chk("sw_asel", {28'b0, asel}, 32'd0);
      mem_model[i] = 32'd0;
      tick();
    end
    @(negedge clk);
    chk("sw_end_busy", {31'b0, busy}, 32'd0);
    tick();
    for (int i = 0; i < 16; i++) access(0, 1'b0, 4'(i), 32'd0);
    tick(); tick();

    // Sweep start beats a simultaneous request.
    sweep_start = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
    @(negedge clk);
    chk("race_gnt1", {31'b0, gnt1}, 32'd0);
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("race_sw_gnt1", {31'b0, gnt1}, 32'd0);
      chk("race_sw_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    pend[1] = 1'b1;
    q1.push_back(mem_model[7]);
    @(negedge clk);
    chk("race_after_gnt1", {31'b0, gnt1}, 32'd1);
    chk("race_after_busy", {31'b0, busy}, 32'd0);
    tick();
    req1 = 1'b0;
    tick(); tick();

    // Reset in the middle of a sweep.
    for (int i = 0; i < 16; i++) access(i % 2, 1'b1, 4'(i), 32'h5000_0000 + i);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (5) tick();
    clr = 1'b1;
    @(negedge clk);
    chk("mid_rst_write", {31'b0, write}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_csel", {28'b0, csel}, 32'd0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_rdata0", rdata0, 32'd0);
    chk("post_rst_rdata1", rdata1, 32'd0);
    for (int i = 0; i < 5; i++) mem_model[i] = 32'd0;
    tick();
    for (int i = 0; i < 16; i++) access(i % 2, 1'b0, 4'(i), 32'd0);
    tick(); tick();

    // Port 1 writes, port 0 reads the same register next cycle.
    access(1, 1'b1, 4'd7, 32'hCAFE_1234);
    access(0, 1'b0, 4'd7, 32'd0);
    tick(); tick(); tick();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
